// File: rtl/apa102_pkg.sv
// Shared types and constants for the APA102 strand decoder.
package apa102_pkg;

  typedef enum logic [1:0] {
    HUNT,
    SYNC,
    WORD
  } state_t;

  localparam int unsigned WORD_W     = 32;
  localparam logic [31:0] START_WORD = 32'h0000_0000;
  localparam logic [31:0] END_WORD   = 32'hFFFF_FFFF;
  localparam logic [2:0]  LED_HDR    = 3'b111;

  // Bit positions of the fields inside one LED word
  localparam int unsigned HDR_MSB = 31;
  localparam int unsigned HDR_LSB = 29;
  localparam int unsigned BRT_MSB = 28;
  localparam int unsigned BRT_LSB = 24;
  localparam int unsigned BLU_MSB = 23;
  localparam int unsigned BLU_LSB = 16;
  localparam int unsigned GRN_MSB = 15;
  localparam int unsigned GRN_LSB = 8;
  localparam int unsigned RED_MSB = 7;
  localparam int unsigned RED_LSB = 0;

endpackage

// File: rtl/sck_edge_sync.sv
// Synchronizes the strand sck/mosi pair into clk and strobes one data bit
// per sck falling edge.
module sck_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sck,
  input  logic mosi,
  output logic bit_strobe,
  output logic bit_value
);

  logic [SYNC_STAGES-1:0] sck_ff;
  logic [SYNC_STAGES-1:0] mosi_ff;
  logic                   sck_prev;

  // Identical chain depths keep mosi aligned with the sck edge it belongs to
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_ff     <= '0;
      mosi_ff    <= '0;
      sck_prev   <= 1'b0;
      bit_strobe <= 1'b0;
      bit_value  <= 1'b0;
    end else begin
      sck_ff     <= {sck_ff[SYNC_STAGES-2:0], sck};
      mosi_ff    <= {mosi_ff[SYNC_STAGES-2:0], mosi};
      sck_prev   <= sck_ff[SYNC_STAGES-1];
      bit_strobe <= sck_prev & ~sck_ff[SYNC_STAGES-1];
      bit_value  <= mosi_ff[SYNC_STAGES-1];
    end
  end

endmodule

// File: rtl/apa102_frame_decoder.sv
// Passive APA102 strand decoder: start-frame hunt, LED word unpack, end-frame check.
// Optional watchdog on a stalled sck is enabled by defining APA102_DEC_TIMEOUT_EN.
module apa102_frame_decoder
  import apa102_pkg::*;
#(
  parameter int unsigned NUM_LEDS    = 12,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sck,
  input  logic       mosi,
  output logic       led_valid,
  output logic [7:0] led_index,
  output logic [4:0] led_brightness,
  output logic [7:0] led_blue,
  output logic [7:0] led_green,
  output logic [7:0] led_red,
  output logic       frame_done,
  output logic [7:0] frame_led_count,
  output logic       hdr_error,
  output logic       len_error,
  output logic       busy
);

  if (NUM_LEDS > 255 || SYNC_STAGES < 2 || TIMEOUT_CYC == 0) begin : g_cfg_check
    $error("apa102_frame_decoder: unsupported parameter set");
  end

  logic              bit_strobe;
  logic              bit_value;
  state_t            state;
  logic [WORD_W-2:0] shreg;
  logic [4:0]        bit_cnt;
  logic [5:0]        zero_cnt;
  logic [7:0]        led_cnt;
  logic [WORD_W-1:0] word;

  sck_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .reset     (reset),
    .sck       (sck),
    .mosi      (mosi),
    .bit_strobe(bit_strobe),
    .bit_value (bit_value)
  );

  // Word as it stands once the incoming bit is shifted in
  assign word = {shreg, bit_value};

`ifdef APA102_DEC_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_cnt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= HUNT;
      shreg           <= START_WORD[WORD_W-2:0];
      bit_cnt         <= '0;
      zero_cnt        <= '0;
      led_cnt         <= '0;
      led_valid       <= 1'b0;
      led_index       <= '0;
      led_brightness  <= '0;
      led_blue        <= '0;
      led_green       <= '0;
      led_red         <= '0;
      frame_done      <= 1'b0;
      frame_led_count <= '0;
      hdr_error       <= 1'b0;
      len_error       <= 1'b0;
      busy            <= 1'b0;
`ifdef APA102_DEC_TIMEOUT_EN
      wd_cnt          <= '0;
`endif
    end else begin
      led_valid  <= 1'b0;
      frame_done <= 1'b0;
      hdr_error  <= 1'b0;
      len_error  <= 1'b0;
`ifdef APA102_DEC_TIMEOUT_EN
      if (bit_strobe || state == HUNT) begin
        wd_cnt <= '0;
      end else if (wd_cnt == WD_W'(TIMEOUT_CYC - 1)) begin
        // Stalled stream: drop the partial word and re-hunt
        wd_cnt    <= '0;
        hdr_error <= 1'b1;
        state     <= HUNT;
        busy      <= 1'b0;
        zero_cnt  <= '0;
      end else begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end
`endif
      if (bit_strobe) begin
        case (state)
          HUNT: begin
            if (bit_value) begin
              zero_cnt <= '0;
            end else if (zero_cnt == 6'(WORD_W - 1)) begin
              zero_cnt <= '0;
              state    <= SYNC;
              busy     <= 1'b1;
            end else begin
              zero_cnt <= zero_cnt + 6'd1;
            end
          end
          SYNC: begin
            // Zero padding is tolerated; the first 1 is bit 31 of LED 0
            if (bit_value) begin
              shreg   <= (WORD_W - 1)'(1);
              bit_cnt <= 5'd1;
              led_cnt <= '0;
              state   <= WORD;
            end
          end
          WORD: begin
            if (bit_cnt == 5'(WORD_W - 1)) begin
              bit_cnt <= '0;
              if (led_cnt == 8'(NUM_LEDS)) begin
                if (word == END_WORD) begin
                  frame_done      <= 1'b1;
                  frame_led_count <= 8'(NUM_LEDS);
                end else begin
                  len_error <= 1'b1;
                end
                state <= HUNT;
                busy  <= 1'b0;
              end else if (word[HDR_MSB:HDR_LSB] != LED_HDR) begin
                hdr_error <= 1'b1;
                state     <= HUNT;
                busy      <= 1'b0;
              end else begin
                led_valid      <= 1'b1;
                led_index      <= led_cnt;
                led_brightness <= word[BRT_MSB:BRT_LSB];
                led_blue       <= word[BLU_MSB:BLU_LSB];
                led_green      <= word[GRN_MSB:GRN_LSB];
                led_red        <= word[RED_MSB:RED_LSB];
                led_cnt        <= led_cnt + 8'd1;
              end
            end else begin
              shreg   <= word[WORD_W-2:0];
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          default: begin
            state <= HUNT;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_apa102_frame_decoder.sv
// Self-checking bench for apa102_frame_decoder: random APA102 streams against a
// word-level frame model; covers APA102_DEC_TIMEOUT_EN when defined.
`timescale 1ns/1ps
module tb_apa102_frame_decoder;

  localparam int unsigned N        = 6;
  localparam int unsigned HALF_BIT = 5;
  localparam logic [1:0]  K_VALID  = 2'd0;
  localparam logic [1:0]  K_DONE   = 2'd1;
  localparam logic [1:0]  K_HDR    = 2'd2;
  localparam logic [1:0]  K_LEN    = 2'd3;

  logic       clk = 1'b0;
  logic       reset;
  logic       sck;
  logic       mosi;
  logic       led_valid;
  logic [7:0] led_index;
  logic [4:0] led_brightness;
  logic [7:0] led_blue;
  logic [7:0] led_green;
  logic [7:0] led_red;
  logic       frame_done;
  logic [7:0] frame_led_count;
  logic       hdr_error;
  logic       len_error;
  logic       busy;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] idx;
    logic [4:0] br;
    logic [7:0] blue;
    logic [7:0] green;
    logic [7:0] red;
    logic [7:0] cnt;
    logic       busy;
  } ev_t;

  ev_t         got_q[$];
  ev_t         exp_q[$];
  logic [31:0] tx_words[$];
  int          tests = 0;
  int          fails = 0;
  int          excl_viol = 0;
  ev_t         mon_e;
  int          mon_np;

  always #5 clk = ~clk;

  apa102_frame_decoder #(
    .NUM_LEDS   (N),
    .SYNC_STAGES(2),
    .TIMEOUT_CYC(4096)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .sck            (sck),
    .mosi           (mosi),
    .led_valid      (led_valid),
    .led_index      (led_index),
    .led_brightness (led_brightness),
    .led_blue       (led_blue),
    .led_green      (led_green),
    .led_red        (led_red),
    .frame_done     (frame_done),
    .frame_led_count(frame_led_count),
    .hdr_error      (hdr_error),
    .len_error      (len_error),
    .busy           (busy)
  );

  // Record every pulse as an event, away from the active edge
  always @(negedge clk) begin
    mon_np = int'(led_valid) + int'(frame_done) + int'(hdr_error) + int'(len_error);
    if (mon_np > 1) excl_viol++;
    if (mon_np > 0 && !reset) begin
      mon_e      = '0;
      mon_e.busy = busy;
      if (led_valid) begin
        mon_e.kind  = K_VALID;
        mon_e.idx   = led_index;
        mon_e.br    = led_brightness;
        mon_e.blue  = led_blue;
        mon_e.green = led_green;
        mon_e.red   = led_red;
      end else if (frame_done) begin
        mon_e.kind = K_DONE;
        mon_e.cnt  = frame_led_count;
      end else if (hdr_error) begin
        mon_e.kind = K_HDR;
      end else begin
        mon_e.kind = K_LEN;
      end
      got_q.push_back(mon_e);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: observed no finish, expected finish within 3 ms");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    sck  = 1'b1;
    mosi = b;
    repeat (HALF_BIT) @(negedge clk);
    sck = 1'b0;
    repeat (HALF_BIT) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_zeros(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0);
  endtask

  function automatic logic [31:0] rand_led();
    return {3'b111, 29'($urandom)};
  endfunction

  // Bad header is never 000 and the word ends in 1, so no 32-zero run appears
  function automatic logic [31:0] rand_bad();
    logic [2:0] h;
    h = 3'($urandom_range(1, 6));
    return {h, 29'($urandom)} | 32'h1;
  endfunction

  // Frame rules at word level: N LED words, then the end word; stop at first error
  task automatic build_model();
    ev_t e;
    int  idx;
    exp_q.delete();
    idx = 0;
    foreach (tx_words[i]) begin
      e = '0;
      if (idx == N) begin
        if (tx_words[i] == 32'hFFFF_FFFF) begin
          e.kind = K_DONE;
          e.cnt  = 8'(N);
        end else begin
          e.kind = K_LEN;
        end
        exp_q.push_back(e);
        return;
      end
      if (tx_words[i][31:29] != 3'b111) begin
        e.kind = K_HDR;
        exp_q.push_back(e);
        return;
      end
      e.kind  = K_VALID;
      e.idx   = 8'(idx);
      e.br    = tx_words[i][28:24];
      e.blue  = tx_words[i][23:16];
      e.green = tx_words[i][15:8];
      e.red   = tx_words[i][7:0];
      e.busy  = 1'b1;
      exp_q.push_back(e);
      idx++;
    end
  endtask

  task automatic run_frame(input string tag, input int pad);
    int n;
    build_model();
    got_q.delete();
    send_zeros(pad + 32);
    foreach (tx_words[i]) send_word(tx_words[i]);
    repeat (20) @(negedge clk);
    chk({tag, "_events"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_ev%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
  endtask

  task automatic plan_frame();
    tx_words.delete();
    for (int i = 0; i < N; i++) tx_words.push_back(32'hFF00_32FF);
    tx_words.push_back(32'hFFFF_FFFF);
  endtask

  initial begin
    logic [31:0] w;
    int          len;
    ev_t         e;

    reset = 1'b1;
    sck   = 1'b0;
    mosi  = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_pulses", 64'({led_valid, frame_done, hdr_error, len_error, busy}), 64'(0));
    chk("rst_fields", 64'({led_index, led_brightness, led_blue, led_green, led_red, frame_led_count}), 64'(0));
    reset = 1'b0;
    repeat (4) @(negedge clk);

    plan_frame();
    run_frame("plan", 0);
    chk("plan_count", 64'(frame_led_count), 64'(N));

    // LED 0 lit, the rest off
    tx_words.delete();
    tx_words.push_back({3'b111, 5'(($urandom_range(1, 31))), 24'($urandom)});
    for (int i = 1; i < N; i++) tx_words.push_back(32'hE000_0000);
    tx_words.push_back(32'hFFFF_FFFF);
    run_frame("led0_on", 7);

    // All-ones word mid-frame is white LED data
    tx_words.delete();
    for (int i = 0; i < N; i++) tx_words.push_back(i == 3 ? 32'hFFFF_FFFF : rand_led());
    tx_words.push_back(32'hFFFF_FFFF);
    run_frame("white3", 3);

    // Bad header at index 2, then a clean frame must decode from index 0
    tx_words.delete();
    tx_words.push_back(32'hFF00_32FF);
    tx_words.push_back(32'hFF00_32FF);
    tx_words.push_back(32'h60FF_00FF);
    for (int i = 3; i < N; i++) tx_words.push_back(rand_led());
    tx_words.push_back(32'hFFFF_FFFF);
    run_frame("hdr2", 0);
    chk("hdr2_busy", 64'(busy), 64'(0));
    plan_frame();
    run_frame("hdr2_recover", 5);

    // Longer strand than configured: length error, then re-sync on next frame
    for (int f = 0; f < 2; f++) begin
      tx_words.delete();
      for (int i = 0; i < N + 2; i++) tx_words.push_back(rand_led());
      tx_words.push_back(32'hFFFF_FFFF);
      run_frame($sformatf("long%0d", f), 40 * f);
    end

    // Random frames with occasional bad headers and extra words
    for (int f = 0; f < 4; f++) begin
      tx_words.delete();
      len = N + $urandom_range(0, 2);
      for (int i = 0; i < len; i++)
        tx_words.push_back(($urandom_range(0, 7) == 0) ? rand_bad() : rand_led());
      tx_words.push_back(32'hFFFF_FFFF);
      run_frame($sformatf("rand%0d", f), $urandom_range(0, 20));
    end

    plan_frame();
    run_frame("pre_reset", 0);

    // Reset after 17 bits of the first LED word
    got_q.delete();
    send_zeros(40);
    w = 32'hFF00_32FF;
    for (int i = 31; i >= 15; i--) send_bit(w[i]);
    chk("midword_busy", 64'(busy), 64'(1));
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_pulses", 64'({led_valid, frame_done, hdr_error, len_error, busy}), 64'(0));
    chk("midrst_fields", 64'({led_index, led_brightness, led_blue, led_green, led_red, frame_led_count}), 64'(0));
    reset = 1'b0;
    for (int i = 14; i >= 0; i--) send_bit(w[i]);
    for (int i = 1; i < N; i++) send_word(rand_led());
    send_word(32'hFFFF_FFFF);
    repeat (20) @(negedge clk);
    chk("midrst_silent", 64'(got_q.size()), 64'(0));
    chk("midrst_idle", 64'(busy), 64'(0));

    plan_frame();
    run_frame("post_reset", 2);

    // Stall sck mid-word
    got_q.delete();
    send_zeros(40);
    for (int i = 31; i >= 22; i--) send_bit(w[i]);
    repeat (5000) @(negedge clk);
`ifdef APA102_DEC_TIMEOUT_EN
    chk("stall_events", 64'(got_q.size()), 64'(1));
    if (got_q.size() > 0) begin
      e      = '0;
      e.kind = K_HDR;
      chk("stall_hdr", 64'(got_q[0]), 64'(e));
    end
    chk("stall_busy", 64'(busy), 64'(0));
`else
    chk("stall_events", 64'(got_q.size()), 64'(0));
    chk("stall_busy", 64'(busy), 64'(1));
`endif

    chk("exclusive_pulses", 64'(excl_viol), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
